// File: rtl/dat_rx_if.sv
// dat_rx_if: handshake/status bundle between the SD read-data receiver and its host side.
// Port summary: master drives start, block_size, block_count, card_in, fifo_full;
//   slave (the receiver) drives data_out, push, busy, done and the four sticky error flags.
interface dat_rx_if #(
  parameter int BLKSZ_W  = 12,
  parameter int BLKCNT_W = 16
);
  logic                start;
  logic [BLKSZ_W-1:0]  block_size;
  logic [BLKCNT_W-1:0] block_count;
  logic [3:0]          card_in;
  logic                fifo_full;
  logic [31:0]         data_out;
  logic                push;
  logic                busy;
  logic                done;
  logic                crc_err;
  logic                end_err;
  logic                timeout_err;
  logic                ovf_err;

  modport master (
    output start, block_size, block_count, card_in, fifo_full,
    input  data_out, push, busy, done, crc_err, end_err, timeout_err, ovf_err
  );

  modport slave (
    input  start, block_size, block_count, card_in, fifo_full,
    output data_out, push, busy, done, crc_err, end_err, timeout_err, ovf_err
  );
endinterface

// File: rtl/dat_rx.sv
// dat_rx: SD host DAT[3:0] read receiver; finds start bits, packs nibbles into 32-bit words, checks per-line CRC16 and end bit, counts blocks.
// Latency: push 1 cycle after a word's 8th nibble is sampled; done 1 cycle after the last END sample or the timeout.
// Backpressure: none toward the card; a word meeting fifo_full is dropped and ovf_err is set, reception continues.
// Ports: clk, reset (async active-low); bus (dat_rx_if.slave): start/block_size/block_count/card_in/fifo_full in,
//   data_out/push/busy/done/crc_err/end_err/timeout_err/ovf_err out.
module dat_rx #(
  parameter int BLKSZ_W  = 12,
  parameter int BLKCNT_W = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic    clk,
  input  logic    reset,
  dat_rx_if.slave bus
);
  localparam int NIB_W = BLKSZ_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE} state_t;

  state_t              state, state_nxt;
  // Block length is kept in bytes: words per block is bsz_q/4, so the nibble count per block is simply 2*bsz_q.
  logic [BLKSZ_W-1:0]  bsz_q;
  logic [BLKCNT_W-1:0] blocks_left;
  // Nibble index within the block while in DATA, reused as the bit index while in CRC.
  logic [NIB_W-1:0]    nib_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [27:0]         shifter;
  logic [31:0]         data_q;
  logic                push_pend;
  logic [3:0][15:0]    crc;
  logic                crc_err_q, end_err_q, tmo_err_q, ovf_err_q;

  logic                start_bit, tmo_hit, last_nib, word_done, crc_last, end_bad, more_blocks;
  logic [3:0]          crc_bad;

  assign start_bit   = (bus.card_in == 4'b0000);
  assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign last_nib    = ((nib_cnt + NIB_W'(1)) == {bsz_q, 1'b0});
  assign word_done   = (nib_cnt[2:0] == 3'd7);
  assign crc_last    = (nib_cnt[3:0] == 4'd15);
  assign end_bad     = (bus.card_in != 4'b1111);
  assign more_blocks = (blocks_left != BLKCNT_W'(1));
  // Each line's received CRC bit is compared with the MSB of its running CRC, which is shifted out one bit per cycle.
  assign crc_bad     = bus.card_in ^ {crc[3][15], crc[2][15], crc[1][15], crc[0][15]};

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:       if (bus.start) state_nxt = S_WAIT_START;
      S_WAIT_START: begin
        if (start_bit)    state_nxt = S_DATA;
        else if (tmo_hit) state_nxt = S_DONE;
      end
      S_DATA:       if (last_nib) state_nxt = S_CRC;
      S_CRC:        if (crc_last) state_nxt = S_END;
      // crc_err_q already holds the result of the last CRC bit here.
      S_END:        state_nxt = (more_blocks && !end_bad && !crc_err_q) ? S_WAIT_START : S_DONE;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bsz_q       <= '0;
      blocks_left <= '0;
      nib_cnt     <= '0;
      tmo_cnt     <= '0;
      shifter     <= '0;
      data_q      <= '0;
      push_pend   <= 1'b0;
      crc         <= '0;
      crc_err_q   <= 1'b0;
      end_err_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      if (push_pend && bus.fifo_full) ovf_err_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bsz_q       <= bus.block_size;
            blocks_left <= (bus.block_count == '0) ? BLKCNT_W'(1) : bus.block_count;
            tmo_cnt     <= '0;
            crc_err_q   <= 1'b0;
            end_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
          end
        end
        S_WAIT_START: begin
          nib_cnt <= '0;
          crc     <= '0;
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (!start_bit && tmo_hit) tmo_err_q <= 1'b1;
        end
        S_DATA: begin
          shifter <= {shifter[23:0], bus.card_in};
          nib_cnt <= last_nib ? '0 : nib_cnt + NIB_W'(1);
          for (int i = 0; i < 4; i++) crc[i] <= crc_step(crc[i], bus.card_in[i]);
          if (word_done) begin
            data_q    <= {shifter, bus.card_in};
            push_pend <= 1'b1;
          end
        end
        S_CRC: begin
          nib_cnt <= nib_cnt + NIB_W'(1);
          for (int i = 0; i < 4; i++) crc[i] <= {crc[i][14:0], 1'b0};
          if (|crc_bad) crc_err_q <= 1'b1;
        end
        S_END: begin
          blocks_left <= blocks_left - BLKCNT_W'(1);
          tmo_cnt     <= '0;
          if (end_bad) end_err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Push is gated combinationally so a word that meets a full FIFO is never written.
  assign bus.data_out    = data_q;
  assign bus.push        = push_pend & ~bus.fifo_full;
  assign bus.busy        = (state != S_IDLE) && (state != S_DONE);
  assign bus.done        = (state == S_DONE);
  assign bus.crc_err     = crc_err_q;
  assign bus.end_err     = end_err_q;
  assign bus.timeout_err = tmo_err_q;
  assign bus.ovf_err     = ovf_err_q;
endmodule
